control_sequencer: RTL and testbench



---
 rtl/control_sequencer_if.sv | 30 +++
 rtl/control_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the DataPath.
// The master side is the sequencer; the slave side is the DataPath (or a bench).
interface control_sequencer_if;
   logic [31:0] ir;
   logic        mem_rdy;
   logic [15:0] reg_en;
   logic [15:0] reg_out;
   logic        Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen;
   logic        ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, HIout, LOout;
   logic [4:0]  alu_control;
   logic        run;
   logic        instr_done;
   logic        mem_fault;

   modport master (
      input  ir, mem_rdy,
      output reg_en, reg_out,
      output Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen,
      output ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, HIout, LOout,
      output alu_control, run, instr_done, mem_fault
   );

   modport slave (
      output ir, mem_rdy,
      input  reg_en, reg_out,
      input  Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen,
      input  ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, HIout, LOout,
      input  alu_control, run, instr_done, mem_fault
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: one state register, outputs decoded from state and IR.
// A fetch that waits MEM_WAIT_MAX cycles on memory latches mem_fault and halts until clr.
module control_sequencer #(
   parameter logic [4:0] INC_OP       = 5'b11111,
   parameter int         MEM_WAIT_MAX = 15
) (
   input  logic clk,
   input  logic clr,
   control_sequencer_if.master bus
);

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);

   typedef enum logic [3:0] {RST, T0, T1, T1W, T2, T3, T4, T5, T6, HALT} state_t;
   typedef enum logic [2:0] {C_ALU3, C_MULDIV, C_MFHI, C_MFLO, C_HALT, C_NOP} cls_t;

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_nxt;
   logic          mem_fault, fault_set;

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   cls_t       cls;
   logic       unused_ir;

   assign opcode    = bus.ir[31:27];
   assign ra        = bus.ir[26:23];
   assign rb        = bus.ir[22:19];
   assign rc        = bus.ir[18:15];
   assign unused_ir = ^bus.ir[14:0];

   logic [15:0] reg_en, reg_out;
   logic        Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen;
   logic        ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, HIout, LOout;
   logic [4:0]  alu_control;
   logic        run, instr_done;

   function automatic logic [15:0] onehot(input logic [3:0] idx);
      onehot = 16'h0001 << idx;
   endfunction

   always_comb begin
      cls = C_NOP;
      if (opcode >= 5'b00011 && opcode <= 5'b01110)
         cls = C_ALU3;
      else if (opcode == 5'b01111 || opcode == 5'b10000)
         cls = C_MULDIV;
      else if (opcode == 5'b10100)
         cls = C_MFHI;
      else if (opcode == 5'b10101)
         cls = C_MFLO;
      else if (opcode == 5'b11011)
         cls = C_HALT;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= RST;
         wait_cnt  <= '0;
         mem_fault <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (fault_set)
            mem_fault <= 1'b1;
      end
   end

   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      fault_set   = 1'b0;
      reg_en      = '0;
      reg_out     = '0;
      Pout        = 1'b0;
      Pen         = 1'b0;
      MARen       = 1'b0;
      MDRen       = 1'b0;
      MDROut      = 1'b0;
      Read        = 1'b0;
      IRen        = 1'b0;
      Yen         = 1'b0;
      ZLOen       = 1'b0;
      ZHIen       = 1'b0;
      ZLOout      = 1'b0;
      ZHIout      = 1'b0;
      HIen        = 1'b0;
      LOen        = 1'b0;
      HIout       = 1'b0;
      LOout       = 1'b0;
      alu_control = '0;
      run         = 1'b1;
      instr_done  = 1'b0;

      case (state)
         RST: state_nxt = T0;

         T0: begin
            Pout        = 1'b1;
            MARen       = 1'b1;
            ZLOen       = 1'b1;
            alu_control = INC_OP;
            state_nxt   = T1;
         end

         T1: begin
            ZLOout    = 1'b1;
            Pen       = 1'b1;
            Read      = 1'b1;
            MDRen     = 1'b1;
            wait_nxt  = '0;
            state_nxt = bus.mem_rdy ? T2 : T1W;
         end

         // PC was already loaded in T1; only the memory read is held here.
         T1W: begin
            Read  = 1'b1;
            MDRen = 1'b1;
            if (bus.mem_rdy) begin
               state_nxt = T2;
            end else if (wait_cnt == CW'(MEM_WAIT_MAX - 1)) begin
               fault_set = 1'b1;
               state_nxt = HALT;
            end else begin
               wait_nxt = wait_cnt + 1'b1;
            end
         end

         T2: begin
            MDROut    = 1'b1;
            IRen      = 1'b1;
            state_nxt = T3;
         end

         T3: begin
            case (cls)
               C_ALU3: begin
                  reg_out   = onehot(rb);
                  Yen       = 1'b1;
                  state_nxt = T4;
               end
               C_MULDIV: begin
                  reg_out   = onehot(ra);
                  Yen       = 1'b1;
                  state_nxt = T4;
               end
               C_MFHI: begin
                  HIout      = 1'b1;
                  reg_en     = onehot(ra);
                  instr_done = 1'b1;
                  state_nxt  = T0;
               end
               C_MFLO: begin
                  LOout      = 1'b1;
                  reg_en     = onehot(ra);
                  instr_done = 1'b1;
                  state_nxt  = T0;
               end
               C_HALT: begin
                  instr_done = 1'b1;
                  state_nxt  = HALT;
               end
               default: begin
                  instr_done = 1'b1;
                  state_nxt  = T0;
               end
            endcase
         end

         T4: begin
            case (cls)
               C_ALU3: begin
                  reg_out     = onehot(rc);
                  alu_control = opcode;
                  ZLOen       = 1'b1;
                  state_nxt   = T5;
               end
               C_MULDIV: begin
                  reg_out     = onehot(rb);
                  alu_control = opcode;
                  ZLOen       = 1'b1;
                  ZHIen       = 1'b1;
                  state_nxt   = T5;
               end
               default: state_nxt = T0;
            endcase
         end

         T5: begin
            case (cls)
               C_ALU3: begin
                  ZLOout     = 1'b1;
                  reg_en     = onehot(ra);
                  instr_done = 1'b1;
                  state_nxt  = T0;
               end
               C_MULDIV: begin
                  ZLOout    = 1'b1;
                  LOen      = 1'b1;
                  state_nxt = T6;
               end
               default: state_nxt = T0;
            endcase
         end

         T6: begin
            ZHIout     = 1'b1;
            HIen       = 1'b1;
            instr_done = 1'b1;
            state_nxt  = T0;
         end

         HALT: run = 1'b0;

         default: state_nxt = RST;
      endcase
   end

   assign bus.reg_en      = reg_en;
   assign bus.reg_out     = reg_out;
   assign bus.Pout        = Pout;
   assign bus.Pen         = Pen;
   assign bus.MARen       = MARen;
   assign bus.MDRen       = MDRen;
   assign bus.MDROut      = MDROut;
   assign bus.Read        = Read;
   assign bus.IRen        = IRen;
   assign bus.Yen         = Yen;
   assign bus.ZLOen       = ZLOen;
   assign bus.ZHIen       = ZHIen;
   assign bus.ZLOout      = ZLOout;
   assign bus.ZHIout      = ZHIout;
   assign bus.HIen        = HIen;
   assign bus.LOen        = LOen;
   assign bus.HIout       = HIout;
   assign bus.LOout       = LOout;
   assign bus.alu_control = alu_control;
   assign bus.run         = run;
   assign bus.instr_done  = instr_done;
   assign bus.mem_fault   = mem_fault;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle expected control words are queued and
// compared against a snapshot of every output taken on the falling edge.
module tb_control_sequencer;

   typedef struct packed {
      logic [15:0] reg_en;
      logic [15:0] reg_out;
      logic Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen;
      logic ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, HIout, LOout;
      logic [4:0]  alu;
      logic run, done, fault;
   } snap_t;

   logic clk;
   logic clr;
   control_sequencer_if bus ();

   control_sequencer #(.INC_OP(5'b11111), .MEM_WAIT_MAX(15)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.master)
   );

   snap_t obs;
   assign obs = {bus.reg_en, bus.reg_out, bus.Pout, bus.Pen, bus.MARen, bus.MDRen,
                 bus.MDROut, bus.Read, bus.IRen, bus.Yen, bus.ZLOen, bus.ZHIen,
                 bus.ZLOout, bus.ZHIout, bus.HIen, bus.LOen, bus.HIout, bus.LOout,
                 bus.alu_control, bus.run, bus.instr_done, bus.mem_fault};

   int    n_tests = 0;
   int    n_fail  = 0;
   snap_t exp_q[$];
   string tag_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic snap_t f_rst();
      snap_t s = '0;
      s.run = 1'b1;
      return s;
   endfunction

   function automatic snap_t f_t0();
      snap_t s = f_rst();
      s.Pout = 1'b1; s.MARen = 1'b1; s.ZLOen = 1'b1; s.alu = 5'b11111;
      return s;
   endfunction

   function automatic snap_t f_t1();
      snap_t s = f_rst();
      s.ZLOout = 1'b1; s.Pen = 1'b1; s.Read = 1'b1; s.MDRen = 1'b1;
      return s;
   endfunction

   function automatic snap_t f_t1w();
      snap_t s = f_rst();
      s.Read = 1'b1; s.MDRen = 1'b1;
      return s;
   endfunction

   function automatic snap_t f_t2();
      snap_t s = f_rst();
      s.MDROut = 1'b1; s.IRen = 1'b1;
      return s;
   endfunction

   function automatic snap_t f_halt(input logic fault);
      snap_t s = '0;
      s.fault = fault;
      return s;
   endfunction

   // Queue the expectation for the current cycle, check it mid-cycle, then advance one edge.
   task automatic step(input string tag, input snap_t e);
      snap_t x;
      string t;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      x = exp_q.pop_front();
      t = tag_q.pop_front();
      n_tests++;
      assert (obs === x) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", t, obs, x);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input string p, input logic [31:0] instr);
      bus.ir      = instr;
      bus.mem_rdy = 1'b1;
      step({p, "_t0"}, f_t0());
      step({p, "_t1"}, f_t1());
      step({p, "_t2"}, f_t2());
   endtask

   initial begin
      snap_t e;
      bus.ir      = 32'h0;
      bus.mem_rdy = 1'b1;
      clr         = 1'b1;
      @(posedge clk);
      #1;

      step("rst_a", f_rst());
      clr = 1'b0;
      step("rst_b", f_rst());

      // and R1,R2,R3
      fetch("and", 32'h2891_8000);
      e = f_rst(); e.reg_out = 16'h0004; e.Yen = 1'b1;
      step("and_t3", e);
      e = f_rst(); e.reg_out = 16'h0008; e.alu = 5'b00101; e.ZLOen = 1'b1;
      step("and_t4", e);
      e = f_rst(); e.ZLOout = 1'b1; e.reg_en = 16'h0002; e.done = 1'b1;
      step("and_t5", e);

      // mul R2,R3
      fetch("mul", 32'h7918_0000);
      e = f_rst(); e.reg_out = 16'h0004; e.Yen = 1'b1;
      step("mul_t3", e);
      e = f_rst(); e.reg_out = 16'h0008; e.alu = 5'b01111; e.ZLOen = 1'b1; e.ZHIen = 1'b1;
      step("mul_t4", e);
      e = f_rst(); e.ZLOout = 1'b1; e.LOen = 1'b1;
      step("mul_t5", e);
      e = f_rst(); e.ZHIout = 1'b1; e.HIen = 1'b1; e.done = 1'b1;
      step("mul_t6", e);

      // mfhi R4 with three memory wait cycles
      bus.ir      = 32'hA200_0000;
      bus.mem_rdy = 1'b0;
      step("mfhi_t0", f_t0());
      step("mfhi_t1", f_t1());
      step("mfhi_w1", f_t1w());
      step("mfhi_w2", f_t1w());
      bus.mem_rdy = 1'b1;
      step("mfhi_w3", f_t1w());
      step("mfhi_t2", f_t2());
      e = f_rst(); e.HIout = 1'b1; e.reg_en = 16'h0010; e.done = 1'b1;
      step("mfhi_t3", e);

      // mflo R5
      fetch("mflo", 32'hAA80_0000);
      e = f_rst(); e.LOout = 1'b1; e.reg_en = 16'h0020; e.done = 1'b1;
      step("mflo_t3", e);

      // nop and an undefined opcode both retire in T3
      fetch("nop", 32'hD000_0000);
      e = f_rst(); e.done = 1'b1;
      step("nop_t3", e);
      fetch("undef", 32'h8800_0000);
      step("undef_t3", e);

      // Memory answers on the last permitted wait cycle: no fault
      bus.ir      = 32'hD000_0000;
      bus.mem_rdy = 1'b0;
      step("edge_t0", f_t0());
      step("edge_t1", f_t1());
      for (int i = 1; i <= 14; i++)
         step($sformatf("edge_w%0d", i), f_t1w());
      bus.mem_rdy = 1'b1;
      step("edge_w15", f_t1w());
      step("edge_t2", f_t2());
      e = f_rst(); e.done = 1'b1;
      step("edge_t3", e);

      // Memory never answers: fault and halt
      bus.mem_rdy = 1'b0;
      step("flt_t0", f_t0());
      step("flt_t1", f_t1());
      for (int i = 1; i <= 15; i++)
         step($sformatf("flt_w%0d", i), f_t1w());
      for (int i = 0; i < 3; i++)
         step($sformatf("flt_halt%0d", i), f_halt(1'b1));
      clr = 1'b1;
      step("flt_clr", f_halt(1'b1));
      clr = 1'b0;
      step("flt_rst", f_rst());
      bus.mem_rdy = 1'b1;

      // halt instruction
      fetch("hlt", 32'hD800_0000);
      e = f_rst(); e.done = 1'b1;
      step("hlt_t3", e);
      for (int i = 0; i < 4; i++)
         step($sformatf("hlt_hold%0d", i), f_halt(1'b0));
      clr = 1'b1;
      step("hlt_clr", f_halt(1'b0));
      clr = 1'b0;
      step("hlt_rst", f_rst());

      // mul aborted by clr in T4: no LOen/HIen afterwards
      fetch("abt", 32'h7918_0000);
      e = f_rst(); e.reg_out = 16'h0004; e.Yen = 1'b1;
      step("abt_t3", e);
      clr = 1'b1;
      e = f_rst(); e.reg_out = 16'h0008; e.alu = 5'b01111; e.ZLOen = 1'b1; e.ZHIen = 1'b1;
      step("abt_t4", e);
      clr = 1'b0;
      step("abt_rst", f_rst());
      step("abt_t0", f_t0());
      step("abt_t1", f_t1());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
